// File: rtl/lsu_dmem.sv
// lsu_dmem: load/store unit between the execute stage and a word-wide data RAM.
// Handles byte/half/word loads with sign/zero extension, sub-word stores via
// read-modify-write (the RAM has no byte enables), and alignment/legality checks.
// All outputs come straight from registers.
module lsu_dmem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // Latched request fields
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [1:0]        off_r;
  logic [15:0]       wdata_r;
  logic              err_r;

  // Output registers
  logic              req_ready_r;
  logic              resp_valid_r;
  logic              resp_err_r;
  logic [31:0]       resp_rdata_r;
  logic              mem_re_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       wbuf_r;

  logic accept_s;
  logic illegal_s;
  logic misaligned_s;
  logic err_s;

  // Address bits above the RAM window are deliberately ignored.
  logic unused_addr_s;
  assign unused_addr_s = ^req_addr[31:ADDR_W+2];

  // Pick the addressed byte/half out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of a RAM word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000: r[{off, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (off[1]) begin
          r[31:16] = wd;
        end else begin
          r[15:0] = wd;
        end
      end
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept_s = req_valid & req_ready_r;

  // Classify the incoming request as illegal or misaligned.
  always_comb begin
    illegal_s    = 1'b1;
    misaligned_s = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
        default:                illegal_s = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_s = 1'b0;
        default:                                illegal_s = 1'b1;
      endcase
    end
    case (req_funct3[1:0])
      2'b01:   misaligned_s = req_addr[0];
      2'b10:   misaligned_s = (req_addr[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
  end

  assign err_s = illegal_s | misaligned_s;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (err_s) begin
            state_next_s = RESP;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            state_next_s = WR;
          end else begin
            state_next_s = RD;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RD:  state_next_s = CAP;
      CAP: begin
        if (we_r) begin
          state_next_s = WR;
        end else begin
          state_next_s = RESP;
        end
      end
      WR:      state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Request latch, write buffer, load result and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      off_r        <= 2'b00;
      wdata_r      <= 16'd0;
      err_r        <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
      mem_re_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      wbuf_r       <= 32'd0;
    end else begin
      req_ready_r  <= (state_next_s == IDLE);
      resp_valid_r <= (state_next_s == RESP);
      mem_re_r     <= (state_next_s == RD);
      mem_we_r     <= (state_next_s == WR);
      if (accept_s) begin
        we_r       <= req_we;
        funct3_r   <= req_funct3;
        off_r      <= req_addr[1:0];
        wdata_r    <= req_wdata[15:0];
        err_r      <= err_s;
        mem_addr_r <= req_addr[ADDR_W+1:2];
        resp_err_r <= err_s;
        if (req_we && (req_funct3 == 3'b010) && !err_s) begin
          wbuf_r <= req_wdata;
        end
      end else begin
        resp_err_r <= (state_next_s == RESP) ? err_r : 1'b0;
      end
      if (state_r == CAP) begin
        if (we_r) begin
          wbuf_r <= store_merge(mem_rdata, wdata_r, funct3_r, off_r);
        end else begin
          resp_rdata_r <= load_extend(mem_rdata, funct3_r, off_r);
        end
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign mem_re     = mem_re_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = wbuf_r;

endmodule
